axi_wrr_arbiter: RTL and testbench
==================================

Name: axi_wrr_arbiter

Overview:
Weighted round-robin, burst-locking arbiter for the AXI NoC: WID requesters, each with a programmable weight of consecutive bursts.
- A grant is registered and held until the granted burst completes (accept && last), so bursts never interleave.
- The search pointer advances past a channel only once its weight credit is exhausted or it stops requesting.
- Sits in front of NoC mux/switch ports in place of plain single-beat round-robin arbitration.

Parameters:
WID, 16, number of requesting channels (any value >= 2, not restricted to powers of 2)
AWID, $clog2(WID), width of channel index
WW, 4, width of each per-channel weight field

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
requests  input  WID  per-channel request, bit i = channel i
weights  input  WID*WW  channel i weight at [i*WW +: WW]; sampled only when loading credit; weight 0 treated as 1
accept  input  1  downstream accepted a beat of the granted burst this cycle
last  input  1  the accepted beat is the final beat of the burst (qualified by accept)
grants  output  WID  registered one-hot grant, all-zero when idle
pos  output  AWID  index of current/last granted channel
busy  output  1  high while a grant is held

Behaviour:
- Reset values: grants=0, pos=0, busy=0, ptr=0, credit=0, state=IDLE.
- Internal registers:
  - ptr (AWID): search start.
  - credit (WW): remaining bursts for channel ptr.
  - state: IDLE / LOCKED.
- Winner g: first channel with requests[g]=1 in order ptr, ptr+1, ..., WID-1, 0, ..., ptr-1.
  - Wrap is modulo WID, not modulo 2^AWID; indices >= WID are never produced.
- IDLE:
  - If any request is high, at the next edge: grants <= onehot(g), pos <= g, busy <= 1, state <= LOCKED.
  - Request-to-grant latency is exactly 1 cycle.
  - If g==ptr and credit!=0: credit is kept.
  - Otherwise: ptr <= g, credit <= max(weight_g,1).
  - No request: all registers hold.
- LOCKED:
  - grants/pos held regardless of the requests inputs; dropping a request mid-burst does not release the grant.
  - accept without last: no change.
  - accept && last (completion):
    - If credit-1 == 0: ptr <= (g+1) mod WID, credit <= 0.
    - Else: credit <= credit-1, ptr stays g.
    - grants <= 0, busy <= 0, state <= IDLE. This gives one idle cycle between bursts unless AXI_WRR_BACK2BACK_EN is defined.
- A channel holding credit is re-granted only if it is still requesting. If it has dropped, the search from ptr selects another channel, which then loads its own weight.
- last without accept: ignored.
- Weights change mid-credit: takes effect on the next credit load only.
- Reset asserted mid-burst: all state returns to reset values immediately (asynchronous); no completion is recorded.
- grants is always one-hot or zero; pos always < WID.

Optional Feature:
AXI_WRR_BACK2BACK_EN
- Defined: on the completion edge, the next winner is computed combinationally from the current requests and from the ptr/credit values updated by this completion. If any request is high, grant goes directly to it (LOCKED -> LOCKED, busy stays 1), with credit load/keep rules as in IDLE. Zero bubble between bursts.
- Undefined: completion always returns to IDLE for one cycle with grants=0 before the next grant.

Test Plan:
- Reset, then requests=16'h0001, weights all 1 -> cycle+1 grants=16'h0001, pos=0, busy=1; hold through accept without last; accept&last -> next cycle grants=0, busy=0, ptr=1.
- requests=16'h8001, all weights 1, one-beat bursts repeated -> grant order 0,15,0,15...; pos never exceeds 15.
- WID=5, requests=5'b10001, weights 1 -> grant order 0,4,0,4; ptr wraps 4->0, never 5..7.
- Weight ch2=3, ch5=1, requests ch2&ch5 constant, single-beat bursts -> order 2,2,2,5,2,2,2,5.
- ch2 weight 3 granted once, then drops request; ch7 requesting -> next grant ch7 with credit 1; ch2 re-raising later is granted with fresh credit 3.
- Reset mid-burst (grants=16'h0010) -> grants=0, busy=0, pos=0 asynchronously. With AXI_WRR_BACK2BACK_EN and requests=16'h0003, weights 1: completion of ch0 -> same edge grants=16'h0002, busy stays 1.

Source files
------------

// File: rtl/axi_wrr_arbiter.sv
// Weighted round-robin arbiter that locks each grant for a whole AXI burst.
// Define AXI_WRR_BACK2BACK_EN to hand over the grant on the completion edge with no idle cycle.
module axi_wrr_arbiter #(
  parameter int WID  = 16,
  parameter int AWID = $clog2(WID),
  parameter int WW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WID-1:0]    requests,
  input  logic [WID*WW-1:0] weights,
  input  logic              accept,
  input  logic              last,
  output logic [WID-1:0]    grants,
  output logic [AWID-1:0]   pos,
  output logic              busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, nxt_state;
  logic [AWID-1:0] ptr, nxt_ptr;
  logic [WW-1:0]   credit, nxt_credit;
  logic [WID-1:0]  nxt_grants;
  logic [AWID-1:0] nxt_pos;
  logic            nxt_busy;

  // Pointer/credit as they stand after this cycle's completion, if any.
  logic [AWID-1:0] base_ptr;
  logic [WW-1:0]   base_credit;
  logic            done;

  logic            win_found;
  logic [AWID-1:0] win_idx;
  logic [WW-1:0]   win_weight;
  logic [WW-1:0]   win_load;
  int              idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    done        = (state == LOCKED) && accept && last;
    base_ptr    = ptr;
    base_credit = credit;
    if (done) begin
      if (credit <= WW'(1)) begin
        base_ptr    = (pos == AWID'(WID - 1)) ? '0 : pos + 1'b1;
        base_credit = '0;
      end else begin
        base_ptr    = pos;
        base_credit = credit - 1'b1;
      end
    end

    // Circular search starting at base_ptr; wrap is modulo WID.
    win_found  = 1'b0;
    win_idx    = '0;
    win_weight = '0;
    idx        = 0;
    for (int i = 0; i < WID; i++) begin
      idx = int'(base_ptr) + i;
      if (idx >= WID) idx = idx - WID;
      if (!win_found && requests[idx]) begin
        win_found  = 1'b1;
        win_idx    = AWID'(idx);
        win_weight = weights[idx*WW +: WW];
      end
    end
    win_load = (win_weight == '0) ? WW'(1) : win_weight;

    nxt_state  = state;
    nxt_ptr    = ptr;
    nxt_credit = credit;
    nxt_grants = grants;
    nxt_pos    = pos;
    nxt_busy   = busy;

    if (done) begin
      nxt_ptr    = base_ptr;
      nxt_credit = base_credit;
      nxt_grants = '0;
      nxt_busy   = 1'b0;
      nxt_state  = IDLE;
    end

`ifdef AXI_WRR_BACK2BACK_EN
    if (win_found && (state == IDLE || done)) begin
`else
    if (win_found && state == IDLE) begin
`endif
      nxt_grants          = '0;
      nxt_grants[win_idx] = 1'b1;
      nxt_pos             = win_idx;
      nxt_busy            = 1'b1;
      nxt_state           = LOCKED;
      // A channel still holding credit keeps it; anyone else starts fresh.
      if (win_idx == base_ptr && base_credit != '0) begin
        nxt_ptr    = base_ptr;
        nxt_credit = base_credit;
      end else begin
        nxt_ptr    = win_idx;
        nxt_credit = win_load;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      credit <= '0;
      grants <= '0;
      pos    <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= nxt_state;
      ptr    <= nxt_ptr;
      credit <= nxt_credit;
      grants <= nxt_grants;
      pos    <= nxt_pos;
      busy   <= nxt_busy;
    end
  end

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// Scoreboard bench for axi_wrr_arbiter: directed bursts push expected grant channels,
// a negedge monitor pops and compares each new grant.
module tb_axi_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] requests = '0;
  logic [63:0] weights = {16{4'h1}};
  logic        accept = 1'b0;
  logic        last = 1'b0;
  logic [15:0] grants;
  logic [3:0]  pos;
  logic        busy;

  logic [4:0]  requests5 = '0;
  logic [19:0] weights5 = {5{4'h1}};
  logic        accept5 = 1'b0;
  logic        last5 = 1'b1;
  logic [4:0]  grants5;
  logic [2:0]  pos5;
  logic        busy5;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int exp5_q[$];

  always #5 clk = ~clk;

  axi_wrr_arbiter #(.WID(16), .WW(4)) dut (
    .clk(clk), .rst_n(rst_n), .requests(requests), .weights(weights),
    .accept(accept), .last(last), .grants(grants), .pos(pos), .busy(busy)
  );

  axi_wrr_arbiter #(.WID(5), .WW(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .requests(requests5), .weights(weights5),
    .accept(accept5), .last(last5), .grants(grants5), .pos(pos5), .busy(busy5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new grant is busy rising, or busy staying high across a completion edge.
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && (!prev_busy || prev_done)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grants), 32'h0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("grant_vec", 32'(grants), 32'h1 << e);
          check("grant_pos", 32'(pos), 32'(e));
        end
      end
      prev_busy = busy;
      prev_done = busy && accept && last;
    end
  end

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("grant_timeout", 32'(busy), 32'h1);
  endtask

  // One granted burst of `beats` beats; requests switch to req_last with the final beat.
  task automatic burst(input int beats, input logic [15:0] req_last);
    wait_busy();
    for (int b = 0; b < beats; b++) begin
      accept = 1'b1;
      last   = (b == beats - 1);
      if (b == beats - 1) requests = req_last;
      @(posedge clk); #1;
    end
    accept = 1'b0;
    last   = 1'b0;
  endtask

  task automatic run_wid5();
    logic pb = 1'b0;
    int   seen = 0;
    int   e;
    exp5_q = '{0, 4, 0, 4};
    requests5 = 5'b10001;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(posedge clk); #1;
      if (busy5 && (!pb || accept5)) begin
        e = exp5_q.pop_front();
        check("w5_pos", 32'(pos5), 32'(e));
        check("w5_vec", 32'(grants5), 32'h1 << e);
        seen++;
        if (seen == 4) requests5 = '0;
      end
      pb      = busy5;
      accept5 = busy5;
    end
    check("w5_count", 32'(seen), 32'd4);
    @(posedge clk); #1;
    accept5 = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("w5_idle", 32'(busy5), 32'h0);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_grants", 32'(grants), 32'h0);
    check("rst_pos", 32'(pos), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Non-power-of-2 channel count: order 0,4,0,4.
    run_wid5();

    // Single channel: grant after one cycle, held through non-last beats.
    exp_q.push_back(0);
    requests = 16'h0001;
    @(posedge clk); #1;
    check("t1_busy", 32'(busy), 32'h1);
    accept = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("t1_hold_grants", 32'(grants), 32'h0001);
    check("t1_hold_busy", 32'(busy), 32'h1);
    accept = 1'b0;
    last = 1'b1;
    requests = 16'h0000;
    @(posedge clk); #1;
    check("t1_last_no_accept", 32'(grants), 32'h0001);
    last = 1'b0;
    burst(1, 16'h0000);
    check("t1_release_grants", 32'(grants), 32'h0);
    check("t1_release_busy", 32'(busy), 32'h0);

    // ptr now 1: channels 0 and 15 alternate starting with 15.
    exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15); exp_q.push_back(0);
    requests = 16'h8001;
    for (int k = 0; k < 4; k++) burst(1, (k == 3) ? 16'h0000 : 16'h8001);

    // ch2 weight 3, ch5 weight 1: order 2,2,2,5,2,2,2,5.
    weights[2*4 +: 4] = 4'd3;
    weights[5*4 +: 4] = 4'd1;
    exp_q = '{2, 2, 2, 5, 2, 2, 2, 5};
    requests = 16'h0024;
    for (int k = 0; k < 8; k++) burst(1, (k == 7) ? 16'h0000 : 16'h0024);

    // ch2 drops while holding credit; ch7 wins, then ch2 returns with fresh credit 3.
    exp_q = '{2, 7, 2, 2, 2, 7};
    requests = 16'h0004;
    burst(2, 16'h0080);
    burst(1, 16'h0084);
    for (int k = 0; k < 4; k++) burst(1, (k == 3) ? 16'h0000 : 16'h0084);
    repeat (2) @(posedge clk);
    #1 check("sb_drain_a", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset in the middle of a burst.
    weights = {16{4'h1}};
    exp_q.push_back(4);
    requests = 16'h0010;
    wait_busy();
    accept = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("mid_rst_grants", 32'(grants), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_pos", 32'(pos), 32'h0);
    accept = 1'b0;
    requests = 16'h0000;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-over from ch0 to ch1 after a completion.
    exp_q = '{0, 1};
    requests = 16'h0003;
    burst(1, 16'h0003);
`ifdef AXI_WRR_BACK2BACK_EN
    check("handover_grants", 32'(grants), 32'h0002);
    check("handover_busy", 32'(busy), 32'h1);
`else
    check("handover_grants", 32'(grants), 32'h0);
    check("handover_busy", 32'(busy), 32'h0);
`endif
    burst(1, 16'h0000);
    repeat (3) @(posedge clk);
    #1 check("sb_drain_b", 32'(exp_q.size()), 32'h0);
    check("final_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
